// File: rtl/fp_sign_stage.sv
// fp_sign_stage: pipelined fp sign manipulation (pass/abs/neg/neg-abs) with class flags and a skid buffer
module fp_sign_stage #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 7,
  parameter int ZERO_CANON = 1,
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sign,
  output logic [2:0]            out_flags
);
  localparam int PW = DATA_WIDTH + 4;
  logic [EXP_WIDTH-1:0] e;
  logic [MAN_WIDTH-1:0] m;
  logic nan, inf, zero, s, ns, in_fire;
  logic [DATA_WIDTH-1:0] res;
  logic [PW-1:0] pkt, out_pkt, skid;
  // classify the incoming operand and build its result packet {flags, orig sign, data}
  always_comb begin
    e = in_data[DATA_WIDTH-2:MAN_WIDTH];
    m = in_data[MAN_WIDTH-1:0];
    s = in_data[DATA_WIDTH-1];
    nan = (&e) & (|m);
    inf = (&e) & ~(|m);
    zero = ~(|e) & ~(|m);
    ns = in_mode[0] ? in_mode[1] : in_mode[1] ^ s;
    res = nan ? in_data : (zero && ZERO_CANON != 0) ? '0 : {ns, in_data[DATA_WIDTH-2:0]};
    pkt = {nan, inf, zero, s, res};
    in_fire = in_valid & in_ready;
  end
  // output register plus one skid entry; in_ready low exactly while the skid entry holds data
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      out_pkt <= '0;
      skid <= '0;
    end else begin
      if (!out_valid || out_ready) begin
        out_valid <= !in_ready || in_fire;
        if (!in_ready) out_pkt <= skid;
        else if (in_fire) out_pkt <= pkt;
      end
      if (!in_ready && out_ready) in_ready <= 1'b1;
      else if (in_fire && out_valid && !out_ready) begin
        in_ready <= 1'b0;
        skid <= pkt;
      end
    end
  end
  assign {out_flags, out_sign, out_data} = out_pkt;
endmodule
